// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial W-bit adder: one shared 4-bit adder stepped LSB-nibble first under a start/done handshake.
// Optional signed-overflow flag and `ovf` port are enabled by defining NSA_OVERFLOW_EN.

module four_bit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 done_valid,
    input  logic                 done_ready
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                 ovf
`endif
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_start_ready;
    logic            r_done_valid;

    logic [3:0]      w_nib;
    logic            w_cout;
    logic            w_last;

    four_bit_adder u_add (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_nib),
        .o_cout (w_cout)
    );

    assign w_last = (r_cnt == CW'(NIBBLES - 1));

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;

    // Top nibble's sign bits decide two's-complement overflow of the whole word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[3] == r_b[3]) && (w_nib[3] != r_a[3]);
        end
    end

    assign ovf = r_ovf;
`endif

    // Handshake flags are registered alongside the state so neither depends on the valid/ready inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_sum         <= '0;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_a           <= a;
                        r_b           <= b;
                        r_carry       <= cin;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= RUN;
                    end
                end
                RUN: begin
                    // Each result nibble enters at the top so the LSB nibble ends up at the bottom.
                    r_sum   <= W'({w_nib, r_sum} >> 4);
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_done_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_done_valid  <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign sum         = r_sum;
    assign cout        = r_carry;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed handshake scenarios plus a randomized
// back-to-back stream checked against plain a+b+cin arithmetic.

module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         done_valid;
    logic         done_ready;
`ifdef NSA_OVERFLOW_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sum         (sum),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef NSA_OVERFLOW_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset start_ready got=%b exp=1", start_ready); end
        tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL reset done_valid got=%b exp=0", done_valid); end
        tests++; if (sum !== '0) begin fails++; $display("FAIL reset sum got=%h exp=0", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset cout got=%b exp=0", cout); end
`ifdef NSA_OVERFLOW_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
    endtask

    // Issues one operation from IDLE and checks timing, result, stall stability and return to IDLE.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input int hold, input bit disturb);
        a = ta; b = tb_v; cin = tcin;
        start_valid = 1'b1; done_ready = (hold == 0);
        @(posedge clk); @(negedge clk);
        tests++; if (start_ready !== 1'b0) begin fails++; $display("FAIL %s accept start_ready got=%b exp=0", name, start_ready); end
        start_valid = disturb;
        for (int k = 0; k < N; k++) begin
            tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL %s early done_valid k=%0d got=%b exp=0", name, k, done_valid); end
            if (disturb) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
            @(posedge clk); @(negedge clk);
        end
        tests++; if (done_valid !== 1'b1) begin fails++; $display("FAIL %s done_valid latency got=%b exp=1", name, done_valid); end
        tests++; if (sum !== e_sum) begin fails++; $display("FAIL %s sum got=%h exp=%h", name, sum, e_sum); end
        tests++; if (cout !== e_cout) begin fails++; $display("FAIL %s cout got=%b exp=%b", name, cout, e_cout); end
`ifdef NSA_OVERFLOW_EN
        tests++; if (ovf !== e_ovf) begin fails++; $display("FAIL %s ovf got=%b exp=%b", name, ovf, e_ovf); end
`endif
        for (int h = 0; h < hold; h++) begin
            if (disturb) begin a = W'($urandom); b = W'($urandom); end
            @(posedge clk); @(negedge clk);
            tests++; if (done_valid !== 1'b1 || start_ready !== 1'b0) begin fails++; $display("FAIL %s stall flags h=%0d got dv=%b sr=%b exp dv=1 sr=0", name, h, done_valid, start_ready); end
            tests++; if (sum !== e_sum || cout !== e_cout) begin fails++; $display("FAIL %s stall result h=%0d got=%b_%h exp=%b_%h", name, h, cout, sum, e_cout, e_sum); end
        end
        done_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start_valid = 1'b0;
        tests++; if (start_ready !== 1'b1 || done_valid !== 1'b0) begin fails++; $display("FAIL %s release got sr=%b dv=%b exp sr=1 dv=0", name, start_ready, done_valid); end
        @(posedge clk); @(negedge clk);
        tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL %s spurious accept start_ready got=%b exp=1", name, start_ready); end
    endtask

    task automatic test_carry_out();
        run_op("carry_out", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_signed_overflow();
        run_op("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_op("stall", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 10, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        run_op("ignore_inputs", 16'hBEEF, 16'h1357, 1'b0, 16'hD246, 1'b0, 1'b0, 3, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        tests++; if (start_ready !== 1'b1 || done_valid !== 1'b0) begin fails++; $display("FAIL mid_reset flags got sr=%b dv=%b exp sr=1 dv=0", start_ready, done_valid); end
        tests++; if (sum !== '0 || cout !== 1'b0) begin fails++; $display("FAIL mid_reset result got=%b_%h exp=0_0000", cout, sum); end
`ifdef NSA_OVERFLOW_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL mid_reset ovf got=%b exp=0", ovf); end
`endif
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL mid_reset late done_valid k=%0d got=%b exp=0", k, done_valid); end
        end
        run_op("after_reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W:0]   q_res[$];
        logic         q_ovf[$];
        logic [W:0]   e;
        logic         eo;
        int           accepts = 0;
        int           results = 0;
        int           prev_acc = -1;
        int           budget = 1000 * (N + 2) + 50;
        done_ready = 1'b1;
        while (results < 1000 && budget > 0) begin
            budget--;
            if (done_valid === 1'b1) begin
                e  = q_res.pop_front();
                eo = q_ovf.pop_front();
                tests++; if ({cout, sum} !== e) begin fails++; $display("FAIL b2b result #%0d got=%b_%h exp=%b_%h", results, cout, sum, e[W], e[W-1:0]); end
`ifdef NSA_OVERFLOW_EN
                tests++; if (ovf !== eo) begin fails++; $display("FAIL b2b ovf #%0d got=%b exp=%b", results, ovf, eo); end
`endif
                results++;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            start_valid = (accepts < 1000);
            if (start_ready === 1'b1 && start_valid) begin
                e = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                q_res.push_back(e);
                q_ovf.push_back((a[W-1] == b[W-1]) && (e[W-1] != a[W-1]));
                if (prev_acc >= 0) begin
                    tests++; if (cyc - prev_acc !== N + 2) begin fails++; $display("FAIL b2b spacing #%0d got=%0d exp=%0d", accepts, cyc - prev_acc, N + 2); end
                end
                prev_acc = cyc;
                accepts++;
            end
            @(posedge clk); @(negedge clk);
        end
        start_valid = 1'b0;
        tests++; if (results !== 1000) begin fails++; $display("FAIL b2b timeout results got=%0d exp=1000", results); end
    endtask

    initial begin
        test_reset();
        test_carry_out();
        test_signed_overflow();
        test_stall();
        test_ignore_inputs();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
